// File: rtl/rsa_pkg.sv
// Shared types and constants for the rsa_unit operand front end.
package rsa_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StCool
   } state_e;

   localparam logic [1:0] ADDR_P     = 2'd0;
   localparam logic [1:0] ADDR_E     = 2'd1;
   localparam logic [1:0] ADDR_M     = 2'd2;
   localparam logic [1:0] ADDR_CONST = 2'd3;

endpackage

// File: rtl/rsa_watchdog.sv
// Run-length watchdog: counts enabled cycles and flags the last allowed one.
module rsa_watchdog #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CntW = $clog2(TIMEOUT);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/rsa_operand_loader.sv
// Byte-wide operand loader and run sequencer in front of rsa_unit.
module rsa_operand_loader
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   input  logic [1:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             rsa_en,
   output logic [WIDTH-1:0] rsa_p,
   output logic [WIDTH-1:0] rsa_e,
   output logic [WIDTH-1:0] rsa_m,
   output logic [WIDTH-1:0] rsa_const,
   input  logic             rsa_eoc,
   input  logic [WIDTH-1:0] rsa_c
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] op_q [4];
   logic [WIDTH-1:0] op_d [4];
   logic [3:0]       loaded_q, loaded_d, loaded_new;
   logic [WIDTH-1:0] result_q, result_d;
   logic             rv_q, rv_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             err_q, err_d;
   logic             first_q, first_d;
   logic             wd_clear, wd_en, wd_expire;

   rsa_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk   (clk),
      .rst   (rst),
      .clear (wd_clear),
      .enable(wd_en),
      .expire(wd_expire)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      loaded_d  = loaded_q;
      result_d  = result_q;
      rv_d      = rv_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      err_d     = 1'b0;
      first_d   = first_q;
      wd_clear  = 1'b0;
      wd_en     = 1'b0;
      // A write in the same cycle as start counts toward the launch check.
      loaded_new = loaded_q | (wr_valid ? (4'b0001 << wr_addr) : 4'b0000);

      unique case (state_q)
         StIdle: begin
            if (wr_valid) begin
               op_d[wr_addr] = wr_data;
               loaded_d      = loaded_new;
            end
            if (start) begin
               if (&loaded_new) begin
                  state_d  = StRun;
                  rv_d     = 1'b0;
                  wd_clear = 1'b1;
                  first_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StRun: begin
            err_d   = wr_valid;
            wd_en   = 1'b1;
            first_d = 1'b0;
            // eoc left over from the previous run is not trusted in the first cycle.
            if (!first_q && rsa_eoc) begin
               result_d = rsa_c;
               rv_d     = 1'b1;
               done_d   = 1'b1;
               state_d  = StCool;
            end else if (wd_expire) begin
               timeout_d = 1'b1;
               state_d   = StCool;
            end
         end
         StCool: begin
            err_d   = wr_valid;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= '{default: '0};
         loaded_q  <= '0;
         result_q  <= '0;
         rv_q      <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         err_q     <= 1'b0;
         first_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         loaded_q  <= loaded_d;
         result_q  <= result_d;
         rv_q      <= rv_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
         first_q   <= first_d;
      end
   end

   assign busy         = (state_q != StIdle);
   assign rsa_en       = (state_q == StRun);
   assign done         = done_q;
   assign timeout      = timeout_q;
   assign err          = err_q;
   assign result       = result_q;
   assign result_valid = rv_q;
   assign rsa_p        = op_q[ADDR_P];
   assign rsa_e        = op_q[ADDR_E];
   assign rsa_m        = op_q[ADDR_M];
   assign rsa_const    = op_q[ADDR_CONST];

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Randomised bench for rsa_operand_loader with a cycle-count reference model.
module tb_rsa_operand_loader;

   localparam int W  = 8;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst, wr_valid, start, rsa_eoc;
   logic [1:0]   wr_addr;
   logic [W-1:0] wr_data, rsa_c;
   logic         busy, done, timeout, err, result_valid, rsa_en;
   logic [W-1:0] result, rsa_p, rsa_e, rsa_m, rsa_const;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] m_op [4];
   logic [3:0]   m_loaded;
   logic [W-1:0] m_result;
   logic         m_rv;

   rsa_operand_loader #(
      .WIDTH  (W),
      .TIMEOUT(TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .err         (err),
      .result      (result),
      .result_valid(result_valid),
      .rsa_en      (rsa_en),
      .rsa_p       (rsa_p),
      .rsa_e       (rsa_e),
      .rsa_m       (rsa_m),
      .rsa_const   (rsa_const),
      .rsa_eoc     (rsa_eoc),
      .rsa_c       (rsa_c)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] get_op(input int a);
      case (a)
         0:       return rsa_p;
         1:       return rsa_e;
         2:       return rsa_m;
         default: return rsa_const;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1; wr_valid = 1'b0; start = 1'b0; rsa_eoc = 1'b0;
      wr_addr = '0; wr_data = '0; rsa_c = '0;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_op[i] = '0;
      m_loaded = '0; m_result = '0; m_rv = 1'b0;
   endtask

   task automatic wr(input int a, input logic [W-1:0] d);
      wr_valid = 1'b1; wr_addr = 2'(a); wr_data = d;
      step();
      wr_valid = 1'b0;
      m_op[a] = d; m_loaded[a] = 1'b1;
      total++;
      if (get_op(a) !== d || err !== 1'b0) begin
         bad++;
         $display("FAIL write: addr=%0d got=%h err=%b want=%h err=0", a, get_op(a), err, d);
      end
   endtask

   // eoc_at: RUN-cycle index (0 = first) where eoc is raised, -1 for never.
   task automatic do_run(input int eoc_at, input logic [W-1:0] c, input bit stale);
      int  exp_end;
      bit  exp_done;
      exp_done = (eoc_at >= 1) && (eoc_at <= TO - 1);
      exp_end  = exp_done ? eoc_at : TO - 1;
      rsa_eoc = stale;
      start = 1'b1;
      step();
      start = 1'b0;
      m_rv = 1'b0;
      total++;
      if (busy !== 1'b1 || rsa_en !== 1'b1 || result_valid !== 1'b0 ||
          {rsa_p, rsa_e, rsa_m, rsa_const} !== {m_op[0], m_op[1], m_op[2], m_op[3]}) begin
         bad++;
         $display("FAIL launch: busy=%b en=%b rv=%b ops=%h want busy=1 en=1 rv=0 ops=%h",
                  busy, rsa_en, result_valid, {rsa_p, rsa_e, rsa_m, rsa_const},
                  {m_op[0], m_op[1], m_op[2], m_op[3]});
      end
      for (int r = 0; r <= exp_end; r++) begin
         rsa_eoc = (r == eoc_at) || (stale && r == 0);
         rsa_c   = rsa_eoc ? c : W'($urandom);
         step();
         total++;
         if (r == exp_end) begin
            if (exp_done) begin
               m_result = c;
               m_rv     = 1'b1;
            end
            if (done !== exp_done || timeout !== !exp_done || rsa_en !== 1'b0 || busy !== 1'b1 ||
                result !== m_result || result_valid !== m_rv) begin
               bad++;
               $display("FAIL run_end r=%0d: done=%b to=%b en=%b busy=%b res=%h rv=%b want done=%b to=%b en=0 busy=1 res=%h rv=%b",
                        r, done, timeout, rsa_en, busy, result, result_valid,
                        exp_done, !exp_done, m_result, m_rv);
            end
         end else if (done !== 1'b0 || timeout !== 1'b0 || rsa_en !== 1'b1) begin
            bad++;
            $display("FAIL run_mid r=%0d: done=%b to=%b en=%b want 0 0 1", r, done, timeout, rsa_en);
         end
      end
      rsa_eoc = 1'b0;
      step();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || rsa_en !== 1'b0 ||
          result !== m_result || result_valid !== m_rv) begin
         bad++;
         $display("FAIL run_idle: busy=%b done=%b to=%b en=%b res=%h rv=%b want 0 0 0 0 %h %b",
                  busy, done, timeout, rsa_en, result, result_valid, m_result, m_rv);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({busy, done, timeout, err, result_valid, rsa_en} !== 6'b0 || result !== '0 ||
          {rsa_p, rsa_e, rsa_m, rsa_const} !== '0) begin
         bad++;
         $display("FAIL reset: flags=%b res=%h ops=%h want all 0",
                  {busy, done, timeout, err, result_valid, rsa_en}, result,
                  {rsa_p, rsa_e, rsa_m, rsa_const});
      end
   endtask

   task automatic test_basic();
      wr(0, 8'h0B); wr(1, 8'h03); wr(2, 8'h05); wr(3, 8'h07);
      do_run(3, 8'h2A, 1'b0);
   endtask

   task automatic test_busy();
      start = 1'b1;
      step();
      start = 1'b0;
      wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 8'hFF;
      step();
      wr_valid = 1'b0;
      total++;
      if (err !== 1'b1 || rsa_m !== m_op[2] || busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_write: err=%b m=%h busy=%b want err=1 m=%h busy=1", err, rsa_m, busy, m_op[2]);
      end
      rsa_eoc = 1'b1; rsa_c = 8'h5C;
      step();
      rsa_eoc = 1'b0;
      m_result = 8'h5C; m_rv = 1'b1;
      total++;
      if (done !== 1'b1 || result !== m_result || err !== 1'b0) begin
         bad++;
         $display("FAIL busy_done: done=%b res=%h err=%b want 1 %h 0", done, result, err, m_result);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || err !== 1'b0 || rsa_en !== 1'b0) begin
         bad++;
         $display("FAIL cool_start: busy=%b err=%b en=%b want 0 0 0", busy, err, rsa_en);
      end
      step();
      total++;
      if (busy !== 1'b0 || rsa_en !== 1'b0 || result_valid !== 1'b1) begin
         bad++;
         $display("FAIL cool_ignored: busy=%b en=%b rv=%b want 0 0 1", busy, rsa_en, result_valid);
      end
   endtask

   task automatic test_partial();
      do_reset();
      wr(0, 8'h11); wr(1, 8'h22);
      start = 1'b1;
      step();
      start = 1'b0;
      total++;
      if (err !== 1'b1 || rsa_en !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL partial_start: err=%b en=%b busy=%b want 1 0 0", err, rsa_en, busy);
      end
      step();
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL partial_after: err=%b busy=%b want 0 0", err, busy);
      end
   endtask

   task automatic test_same_cycle();
      logic [W-1:0] d;
      do_reset();
      wr(0, W'($urandom)); wr(1, W'($urandom)); wr(2, W'($urandom));
      d = W'($urandom);
      wr_valid = 1'b1; wr_addr = 2'd3; wr_data = d; start = 1'b1;
      step();
      wr_valid = 1'b0; start = 1'b0;
      m_op[3] = d; m_loaded[3] = 1'b1;
      total++;
      if (busy !== 1'b1 || rsa_en !== 1'b1 || rsa_const !== d || err !== 1'b0) begin
         bad++;
         $display("FAIL same_cycle: busy=%b en=%b const=%h err=%b want 1 1 %h 0", busy, rsa_en, rsa_const, err, d);
      end
      step();
      rsa_eoc = 1'b1; rsa_c = 8'h3E;
      step();
      rsa_eoc = 1'b0;
      m_result = 8'h3E; m_rv = 1'b1;
      total++;
      if (done !== 1'b1 || result !== m_result) begin
         bad++;
         $display("FAIL same_cycle_done: done=%b res=%h want 1 %h", done, result, m_result);
      end
      step();
   endtask

   task automatic test_reset_midrun();
      wr(0, 8'h01); wr(1, 8'h02); wr(2, 8'h03); wr(3, 8'h04);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_op[i] = '0;
      m_loaded = '0; m_result = '0; m_rv = 1'b0;
      total++;
      if ({busy, done, timeout, err, result_valid, rsa_en} !== 6'b0 || result !== '0 ||
          {rsa_p, rsa_e, rsa_m, rsa_const} !== '0) begin
         bad++;
         $display("FAIL midrun_reset: flags=%b res=%h ops=%h want all 0",
                  {busy, done, timeout, err, result_valid, rsa_en}, result,
                  {rsa_p, rsa_e, rsa_m, rsa_const});
      end
      start = 1'b1;
      step();
      start = 1'b0;
      total++;
      if (err !== 1'b1 || rsa_en !== 1'b0) begin
         bad++;
         $display("FAIL midrun_restart: err=%b en=%b want 1 0", err, rsa_en);
      end
      step();
   endtask

   task automatic test_random();
      do_reset();
      for (int a = 0; a < 4; a++) wr(a, W'($urandom));
      for (int it = 0; it < 25; it++) begin
         int n;
         int e;
         n = int'($urandom_range(0, 3));
         for (int k = 0; k < n; k++) wr(int'($urandom_range(0, 3)), W'($urandom));
         e = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TO + 2));
         do_run(e, W'($urandom), bit'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy();
      do_run(-1, 8'h00, 1'b0);
      do_run(2, 8'h99, 1'b1);
      do_run(TO - 1, 8'h77, 1'b0);
      test_same_cycle();
      test_partial();
      test_reset_midrun();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rsa_operand_loader.md
# rsa_operand_loader

Byte-wide front end for `rsa_unit`, replacing the direct tie of all four operand inputs to one input bus. A host writes P, E, M and Const into addressed registers, then issues a start pulse. The block holds the operands stable, drives the unit's enable, waits for end-of-conversion under a watchdog, and captures C into a result register. It sits directly upstream of `rsa_unit` and also consumes that unit's `eoc`/`C` outputs.

## Interface
- `WIDTH`, 8: operand/result width; must match `rsa_unit`.
- `TIMEOUT`, 1024: max RUN cycles before abort; ≥ 2.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `wr_valid` in 1: operand write strobe.
- `wr_addr` in 2: operand select; 0=P, 1=E, 2=M, 3=Const.
- `wr_data` in WIDTH: operand value.
- `start` in 1: launch request, sampled each cycle.
- `busy` out 1: high in RUN and COOL.
- `done` out 1: one-cycle pulse when a result is captured.
- `timeout` out 1: one-cycle pulse when the watchdog aborts a run.
- `err` out 1: one-cycle pulse on a rejected write or start.
- `result` out WIDTH: captured C.
- `result_valid` out 1: `result` holds the output of the latest launch.
- `rsa_en` out 1: enable to `rsa_unit.en`.
- `rsa_p`, `rsa_e`, `rsa_m`, `rsa_const` out WIDTH: operand registers to `rsa_unit`.
- `rsa_eoc` in 1: from `rsa_unit.eoc`.
- `rsa_c` in WIDTH: from `rsa_unit.C`.

## Operation
- Reset value of every output is 0, including the operand registers. The 4-bit `loaded` mask, watchdog count and state are also cleared.
- **States:** IDLE, RUN, COOL.
- **IDLE, `wr_valid`:** write `wr_data` into the addressed register and set its `loaded` bit.
- **IDLE, `start`:**
  - If `loaded` (including any write in the same cycle) is 4'b1111: go to RUN, clear `result_valid`, clear the watchdog.
  - Otherwise: stay in IDLE and pulse `err`.
- **Write and start in the same IDLE cycle:** the write lands and is included in the launched operands.
- **RUN:**
  - `rsa_en`=1 and the watchdog increments each cycle.
  - `rsa_eoc` is ignored in the first RUN cycle (stale-eoc guard) and sampled from the second onward.
  - On sampled eoc: `result`←`rsa_c`, `result_valid`=1, pulse `done`, go to COOL.
  - Else, if the watchdog reaches TIMEOUT-1: pulse `timeout`, leave `result_valid`=0, go to COOL.
  - eoc and watchdog expiry in the same cycle: eoc wins.
- **COOL:** `rsa_en`=0 for exactly one cycle so `rsa_unit` re-arms; then go to IDLE.
- **While busy:**
  - `wr_valid` is dropped, operand registers are unchanged, `err` pulses.
  - `start` is ignored silently (no `err`).
- Operands and `loaded` persist after a run; re-issuing `start` reuses them.
- `rst` mid-run: immediate return to IDLE with all outputs at reset values. `rsa_en` drops on the next edge.

## Timing
- `start` sampled at edge N (IDLE, all loaded) → `rsa_en`=1 and `busy`=1 from N+1.
- A write at edge N is visible on `rsa_*` from N+1.
- eoc sampled at edge K → `done`, `result`, `result_valid` visible from K+1; `rsa_en`=0 at K+1; `busy`=0 and IDLE at K+2.
- Earliest valid eoc is the 2nd RUN cycle, so minimum start-to-done is 3 cycles.
- Timeout: `timeout` is asserted TIMEOUT cycles after `rsa_en` rises.
- The earliest next accepted `start` is the edge at which `busy` is first seen low.

## Structure
- Shared package `rsa_pkg`:
  - state enum (IDLE, RUN, COOL);
  - operand address constants `ADDR_P`=0, `ADDR_E`=1, `ADDR_M`=2, `ADDR_CONST`=3.
- One sub-module, `rsa_watchdog`:
  - inputs: clear, enable;
  - output: expire, asserted at count TIMEOUT-1;
  - counter width `$clog2(TIMEOUT)`.

## Test plan
- Write P=0x0B, E=0x03, M=0x05, Const=0x07, then start; model asserts `rsa_eoc` on the 4th RUN cycle with C=0x2A → `done` pulses once, `result`=0x2A, `result_valid`=1, `busy` low two cycles after eoc.
- Start after writing only P and E → `err` pulses one cycle, `rsa_en` stays 0, state stays IDLE.
- Write M=0xFF during RUN → `err` pulses, `rsa_m` unchanged. A `start` during COOL is ignored.
- Model never raises eoc, TIMEOUT=16 → `timeout` pulses 16 cycles after `rsa_en` rose, `result_valid`=0, IDLE two cycles later.
- `rsa_eoc` held high entering RUN, then dropped → first-cycle eoc is ignored; the later eoc captures `result`.
- `rst` asserted mid-RUN → next cycle all outputs 0 and `loaded` cleared; a subsequent start with no writes → `err`.
